// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with jump, branch and call/return.
// Optional return-address stack enabled by macro PC_UNIT_RAS_EN.
//
// Ports:
//   CLK, RESET_N        clock, async active-low reset
//   PC_EN               advance enable (0 = stall, strobes ignored)
//   JUMP, JUMP_ADDR     absolute jump and its target (also the CALL target)
//   BRANCH, BR_OFFSET   PC-relative branch, two's-complement offset
//   CALL, RET           push return address / pop into PC
//   PC, PC_NEXT         registered PC, value it takes at the next edge
//   RAS_EMPTY/FULL/ERR  stack status, ERR is sticky over/underflow
module pc_unit #(
  parameter int                  PC_WIDTH     = 16,
  parameter int                  STEP         = 1,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                PC_EN,
  input  logic                JUMP,
  input  logic [PC_WIDTH-1:0] JUMP_ADDR,
  input  logic                BRANCH,
  input  logic [PC_WIDTH-1:0] BR_OFFSET,
  input  logic                CALL,
  input  logic                RET,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PC_NEXT,
  output logic                RAS_EMPTY,
  output logic                RAS_FULL,
  output logic                RAS_ERR
);

  localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ret_hit;
  logic                ret_miss;

  assign pc_inc = pc_q + STEP_W;

`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] stk_q [RAS_DEPTH];
  logic [PW-1:0]       wp_q;
  logic [PW-1:0]       wp_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                empty_q;
  logic                full_q;
  logic                err_q;
  logic                err_d;
  logic                push;
  logic                pop;

  assign ret_hit  = RET && (cnt_q != '0);
  assign ret_miss = RET && (cnt_q == '0);
  assign push     = PC_EN && !RET && CALL;
  assign pop      = PC_EN && ret_hit;
  // wp_q is the next write slot; the newest entry sits just below it.
  assign ras_top  = stk_q[wp_q - PW'(1)];

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      // When full, wp_q already points at the oldest entry.
      wp_d = wp_q + PW'(1);
      if (cnt_q == CMAX) err_d = 1'b1;
      else cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      wp_d  = wp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
    if (PC_EN && ret_miss) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      if (push) stk_q[wp_q] <= pc_inc;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CMAX);
      err_q   <= err_d;
    end
  end

  assign RAS_EMPTY = empty_q;
  assign RAS_FULL  = full_q;
  assign RAS_ERR   = err_q;
`else
  logic unused_ret;

  assign unused_ret = RET;
  assign ret_hit    = 1'b0;
  assign ret_miss   = 1'b0;
  assign ras_top    = '0;
  assign RAS_EMPTY  = 1'b1;
  assign RAS_FULL   = 1'b0;
  assign RAS_ERR    = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (PC_EN) begin
      if (ret_hit)             pc_d = ras_top;
      else if (ret_miss)       pc_d = pc_inc;
      else if (CALL || JUMP)   pc_d = JUMP_ADDR;
      else if (BRANCH)         pc_d = pc_q + BR_OFFSET;
      else                     pc_d = pc_inc;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) pc_q <= RESET_VECTOR;
    else          pc_q <= pc_d;
  end

  assign PC      = pc_q;
  assign PC_NEXT = pc_d;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus for pc_unit with a queue-based
// reference model compared every cycle plus literal checkpoints.
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PC_EN = 1'b0;
  logic        JUMP = 1'b0;
  logic [15:0] JUMP_ADDR = '0;
  logic        BRANCH = 1'b0;
  logic [15:0] BR_OFFSET = '0;
  logic        CALL = 1'b0;
  logic        RET = 1'b0;
  logic [15:0] PC;
  logic [15:0] PC_NEXT;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RAS_ERR;

  pc_unit #(
    .PC_WIDTH(16), .STEP(1), .RESET_VECTOR(16'h0000), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC_EN(PC_EN),
    .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR),
    .BRANCH(BRANCH), .BR_OFFSET(BR_OFFSET),
    .CALL(CALL), .RET(RET),
    .PC(PC), .PC_NEXT(PC_NEXT),
    .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL), .RAS_ERR(RAS_ERR)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  // Reference model: PC value, return stack as a queue (back = newest).
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_q[$];
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] m_next();
    if (!PC_EN) return m_pc;
    if (RAS && RET && m_q.size() > 0) return m_q[m_q.size()-1];
    if (RAS && RET) return m_pc + 16'd1;
    if (CALL || JUMP) return JUMP_ADDR;
    if (BRANCH) return m_pc + BR_OFFSET;
    return m_pc + 16'd1;
  endfunction

  task automatic m_reset();
    m_pc = 16'h0000;
    m_q.delete();
    m_err = 1'b0;
  endtask

  always @(posedge CLK) begin
    if (RESET_N && PC_EN) begin
      logic [15:0] nx;
      nx = m_next();
      if (RAS && RET) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else m_err = 1'b1;
      end else if (RAS && CALL) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_err = 1'b1;
        end
        m_q.push_back(m_pc + 16'd1);
      end
      m_pc = nx;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("pc", PC, m_pc);
      chk("pc_next", PC_NEXT, m_next());
      chk("ras_empty", {15'd0, RAS_EMPTY},
          {15'd0, (RAS ? m_q.size() == 0 : 1'b1)});
      chk("ras_full", {15'd0, RAS_FULL},
          {15'd0, (RAS ? m_q.size() == DEPTH : 1'b0)});
      chk("ras_err", {15'd0, RAS_ERR}, {15'd0, m_err});
    end
  end

  task automatic apply(input logic en, input logic ret, input logic call,
                       input logic jmp, input logic br,
                       input logic [15:0] addr, input logic [15:0] off);
    PC_EN = en; RET = ret; CALL = call; JUMP = jmp; BRANCH = br;
    JUMP_ADDR = addr; BR_OFFSET = off;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    m_reset();
    #1;
    chk("rst_pc", PC, 16'h0000);
    chk("rst_empty", {15'd0, RAS_EMPTY}, 16'd1);
    chk("rst_err", {15'd0, RAS_ERR}, 16'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    m_reset();
    chk_on = 1'b1;
    @(posedge CLK);
    #1;
    chk("por_pc", PC, 16'h0000);
    chk("por_full", {15'd0, RAS_FULL}, 16'd0);
    RESET_N = 1'b1;

    // Sequential run, then stall with strobes that must be ignored.
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("count5", PC, 16'h0005);
    apply(0, 1, 1, 1, 1, 16'h1234, 16'h0100);
    chk("stall_next", PC_NEXT, 16'h0005);
    apply(0, 0, 1, 0, 0, 16'h4321, 16'h0);
    apply(0, 1, 0, 0, 1, 16'h0, 16'h0010);
    chk("stall3", PC, 16'h0005);

    // Negative branch and wrap-around.
    apply(1, 0, 0, 1, 0, 16'h0010, 16'h0);
    chk("jump10", PC, 16'h0010);
    apply(1, 0, 0, 0, 1, 16'h0, 16'hFFF8);
    chk("branch_neg", PC, 16'h0008);
    apply(1, 0, 0, 1, 0, 16'hFFFF, 16'h0);
    apply(1, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("wrap", PC, 16'h0000);

    // Call then immediate return.
    apply(1, 0, 0, 1, 0, 16'h0020, 16'h0);
    apply(1, 0, 1, 0, 0, 16'h0100, 16'h0);
    chk("call", PC, 16'h0100);
    apply(1, 1, 0, 0, 0, 16'h0, 16'h0);
    chk("ret", PC, RAS ? 16'h0021 : 16'h0101);
    chk("ret_empty", {15'd0, RAS_EMPTY}, 16'd1);

    // Five nested calls overflow a 4-deep stack.
    apply(1, 0, 0, 1, 0, 16'h0200, 16'h0);
    for (int i = 0; i < 5; i++)
      apply(1, 0, 1, 0, 0, 16'h0300 + 16'(i) * 16'h0100, 16'h0);
    chk("ovf_pc", PC, 16'h0700);
    chk("ovf_full", {15'd0, RAS_FULL}, RAS ? 16'd1 : 16'd0);
    chk("ovf_err", {15'd0, RAS_ERR}, RAS ? 16'd1 : 16'd0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 0, 0, 0, 16'h0, 16'h0);
      chk("lifo", PC, RAS ? 16'h0601 - 16'(i) * 16'h0100
                          : 16'h0701 + 16'(i));
    end
    chk("lifo_empty", {15'd0, RAS_EMPTY}, 16'd1);

    // Underflow and RET-over-JUMP priority.
    do_reset();
    apply(1, 0, 0, 1, 0, 16'h0040, 16'h0);
    apply(1, 1, 0, 0, 0, 16'h0, 16'h0);
    chk("unf_pc", PC, 16'h0041);
    chk("unf_err", {15'd0, RAS_ERR}, RAS ? 16'd1 : 16'd0);
    apply(1, 0, 1, 0, 0, 16'h0080, 16'h0);
    apply(1, 1, 0, 1, 0, 16'h0999, 16'h0);
    chk("ret_prio", PC, RAS ? 16'h0042 : 16'h0999);

    // Asynchronous reset mid-cycle with two entries stacked.
    do_reset();
    apply(1, 0, 1, 0, 0, 16'h0500, 16'h0);
    apply(1, 0, 1, 0, 0, 16'h0600, 16'h0);
    apply(1, 0, 0, 0, 0, 16'h0, 16'h0);
    #2;
    do_reset();
    apply(1, 1, 0, 0, 0, 16'h0, 16'h0);
    chk("post_rst_ret", PC, 16'h0001);
    apply(1, 0, 0, 0, 0, 16'h0, 16'h0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
